// File: rtl/mem_access_ctrl_pkg.sv
// Shared definitions for the MEM-stage data-bus access controller:
// FSM encodings, bus idle constants and the kseg address mask.
package mem_access_ctrl_pkg;

    typedef enum logic [2:0] {
        MAC_IDLE   = 3'd0,
        MAC_ADDR   = 3'd1,
        MAC_DATA   = 3'd2,
        MAC_CANCEL = 3'd3,
        MAC_DONE   = 3'd4
    } mac_state_e;

    localparam logic [3:0]  WrDisable = 4'b0000;
    localparam logic [31:0] ZeroWord  = 32'h0000_0000;
    localparam logic [31:0] KsegMask  = 32'h1FFF_FFFF;

endpackage

// File: rtl/mem_access_ctrl_addr_map.sv
// Combinational virtual-to-physical translation for unmapped kseg0/kseg1
// windows; shared with the instruction fetch side.
module mem_access_ctrl_addr_map
    import mem_access_ctrl_pkg::*;
#(
    parameter int KSEG_MAP = 1
) (
    input  logic [31:0] vaddr,
    output logic [31:0] paddr
);

    logic kseg_hit_s;

    assign kseg_hit_s = (vaddr[31:30] == 2'b10);

    // Strip the segment bits only for kseg0/kseg1 when mapping is enabled
    always_comb begin
        paddr = vaddr;
        if ((KSEG_MAP != 0) && kseg_hit_s) begin
            paddr = vaddr & KsegMask;
        end else begin
            paddr = vaddr;
        end
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// Sequences MEM-stage loads/stores onto the req/addr_ok/data_ok data bus,
// stalls the pipeline while an access is outstanding and absorbs flushes.
module mem_access_ctrl
    import mem_access_ctrl_pkg::*;
#(
    parameter int KSEG_MAP = 1,
    parameter int CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mem_m_en,
    input  logic [3:0]       mem_m_wen,
    input  logic [31:0]      mem_m_vaddr,
    input  logic [31:0]      mem_m_wdata,
    input  logic             mem_excp_valid,
    input  logic             flush,
    input  logic             mem_adv,
    output logic             stall_req,
    output logic [31:0]      m_rdata,
    output logic             d_req,
    output logic             d_wr,
    output logic [3:0]       d_wen,
    output logic [31:0]      d_addr,
    output logic [31:0]      d_wdata,
    input  logic             d_addr_ok,
    input  logic             d_data_ok,
    input  logic [31:0]      d_rdata,
    output logic [CNT_W-1:0] stall_cnt
);

    mac_state_e       state_r, next_state_s;
    logic             go_s;
    logic             stall_req_s;
    logic [31:0]      paddr_s;
    logic             d_req_r, d_req_nxt_s;
    logic             d_wr_r, d_wr_nxt_s;
    logic [3:0]       d_wen_r, d_wen_nxt_s;
    logic [31:0]      d_addr_r, d_addr_nxt_s;
    logic [31:0]      d_wdata_r, d_wdata_nxt_s;
    logic [31:0]      m_rdata_r, m_rdata_nxt_s;
    logic [CNT_W-1:0] stall_cnt_r;

    mem_access_ctrl_addr_map #(
        .KSEG_MAP (KSEG_MAP)
    ) u_addr_map (
        .vaddr (mem_m_vaddr),
        .paddr (paddr_s)
    );

    assign go_s = mem_m_en & ~mem_excp_valid & ~flush;

    // Next-state, next bus-register values and the combinational stall request
    always_comb begin
        next_state_s  = state_r;
        d_req_nxt_s   = d_req_r;
        d_wr_nxt_s    = d_wr_r;
        d_wen_nxt_s   = d_wen_r;
        d_addr_nxt_s  = d_addr_r;
        d_wdata_nxt_s = d_wdata_r;
        m_rdata_nxt_s = m_rdata_r;
        stall_req_s   = 1'b0;
        case (state_r)
            MAC_IDLE: begin
                stall_req_s = go_s;
                if (go_s) begin
                    d_req_nxt_s   = 1'b1;
                    d_wr_nxt_s    = (mem_m_wen != WrDisable);
                    d_wen_nxt_s   = mem_m_wen;
                    d_addr_nxt_s  = paddr_s;
                    d_wdata_nxt_s = mem_m_wdata;
                    next_state_s  = MAC_ADDR;
                end else begin
                    next_state_s  = MAC_IDLE;
                end
            end
            MAC_ADDR: begin
                stall_req_s = 1'b1;
                // A flush here drops a request the bus never accepted
                if (flush) begin
                    d_req_nxt_s  = 1'b0;
                    next_state_s = MAC_IDLE;
                end else if (d_addr_ok) begin
                    d_req_nxt_s  = 1'b0;
                    next_state_s = MAC_DATA;
                end else begin
                    next_state_s = MAC_ADDR;
                end
            end
            MAC_DATA: begin
                stall_req_s = 1'b1;
                if (d_data_ok && flush) begin
                    next_state_s = MAC_IDLE;
                end else if (d_data_ok) begin
                    if (!d_wr_r) begin
                        m_rdata_nxt_s = d_rdata;
                    end else begin
                        m_rdata_nxt_s = m_rdata_r;
                    end
                    next_state_s = MAC_DONE;
                end else if (flush) begin
                    next_state_s = MAC_CANCEL;
                end else begin
                    next_state_s = MAC_DATA;
                end
            end
            MAC_CANCEL: begin
                // Accepted request must drain before the new occupant issues
                stall_req_s = 1'b1;
                if (d_data_ok) begin
                    next_state_s = MAC_IDLE;
                end else begin
                    next_state_s = MAC_CANCEL;
                end
            end
            MAC_DONE: begin
                stall_req_s = 1'b0;
                if (mem_adv || flush) begin
                    next_state_s = MAC_IDLE;
                end else begin
                    next_state_s = MAC_DONE;
                end
            end
            default: begin
                stall_req_s  = 1'b0;
                d_req_nxt_s  = 1'b0;
                next_state_s = MAC_IDLE;
            end
        endcase
    end

    // State and registered bus/read-data outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= MAC_IDLE;
            d_req_r   <= 1'b0;
            d_wr_r    <= 1'b0;
            d_wen_r   <= WrDisable;
            d_addr_r  <= ZeroWord;
            d_wdata_r <= ZeroWord;
            m_rdata_r <= ZeroWord;
        end else begin
            state_r   <= next_state_s;
            d_req_r   <= d_req_nxt_s;
            d_wr_r    <= d_wr_nxt_s;
            d_wen_r   <= d_wen_nxt_s;
            d_addr_r  <= d_addr_nxt_s;
            d_wdata_r <= d_wdata_nxt_s;
            m_rdata_r <= m_rdata_nxt_s;
        end
    end

    // Saturating count of stalled cycles
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_r <= {CNT_W{1'b0}};
        end else if (stall_req_s && (stall_cnt_r != {CNT_W{1'b1}})) begin
            stall_cnt_r <= stall_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            stall_cnt_r <= stall_cnt_r;
        end
    end

    assign stall_req = stall_req_s;
    assign d_req     = d_req_r;
    assign d_wr      = d_wr_r;
    assign d_wen     = d_wen_r;
    assign d_addr    = d_addr_r;
    assign d_wdata   = d_wdata_r;
    assign m_rdata   = m_rdata_r;
    assign stall_cnt = stall_cnt_r;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed-vector bench for mem_access_ctrl; a narrow stall counter is used
// so that saturation is reached within the directed sequence.
module tb_mem_access_ctrl;

    localparam int CW = 4;

    logic          clk;
    logic          rst;
    logic          mem_m_en;
    logic [3:0]    mem_m_wen;
    logic [31:0]   mem_m_vaddr;
    logic [31:0]   mem_m_wdata;
    logic          mem_excp_valid;
    logic          flush;
    logic          mem_adv;
    logic          stall_req;
    logic [31:0]   m_rdata;
    logic          d_req;
    logic          d_wr;
    logic [3:0]    d_wen;
    logic [31:0]   d_addr;
    logic [31:0]   d_wdata;
    logic          d_addr_ok;
    logic          d_data_ok;
    logic [31:0]   d_rdata;
    logic [CW-1:0] stall_cnt;

    int n_vec = 0;
    int n_err = 0;

    mem_access_ctrl #(
        .KSEG_MAP (1),
        .CNT_W    (CW)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .mem_m_en       (mem_m_en),
        .mem_m_wen      (mem_m_wen),
        .mem_m_vaddr    (mem_m_vaddr),
        .mem_m_wdata    (mem_m_wdata),
        .mem_excp_valid (mem_excp_valid),
        .flush          (flush),
        .mem_adv        (mem_adv),
        .stall_req      (stall_req),
        .m_rdata        (m_rdata),
        .d_req          (d_req),
        .d_wr           (d_wr),
        .d_wen          (d_wen),
        .d_addr         (d_addr),
        .d_wdata        (d_wdata),
        .d_addr_ok      (d_addr_ok),
        .d_data_ok      (d_data_ok),
        .d_rdata        (d_rdata),
        .stall_cnt      (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cnt_is(input string tag, input int exp);
        chk(tag, {28'h0, stall_cnt}, exp[31:0]);
    endtask

    initial begin
        rst = 1'b1; mem_m_en = 1'b0; mem_m_wen = 4'b0000; mem_m_vaddr = 32'h0;
        mem_m_wdata = 32'h0; mem_excp_valid = 1'b0; flush = 1'b0; mem_adv = 1'b0;
        d_addr_ok = 1'b0; d_data_ok = 1'b0; d_rdata = 32'h0;
        tick(); tick();
        rst = 1'b0;
        @(negedge clk);
        chk("rst_d_req", {31'h0, d_req}, 32'h0);
        chk("rst_d_addr", d_addr, 32'h0);
        chk("rst_m_rdata", m_rdata, 32'h0);
        chk("rst_stall", {31'h0, stall_req}, 32'h0);
        cnt_is("rst_cnt", 0);
        tick();

        // exception suppresses the access and does not count
        mem_m_en = 1'b1; mem_excp_valid = 1'b1; mem_m_vaddr = 32'h8000_0200;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("excp_stall", {31'h0, stall_req}, 32'h0);
            tick();
            chk("excp_d_req", {31'h0, d_req}, 32'h0);
        end
        cnt_is("excp_cnt", 0);
        mem_excp_valid = 1'b0;

        // 1: zero-wait load from kseg0
        mem_m_en = 1'b1; mem_m_wen = 4'b0000; mem_m_vaddr = 32'h8000_1000;
        @(negedge clk); chk("ld_stall_idle", {31'h0, stall_req}, 32'h1);
        tick();
        d_addr_ok = 1'b1;
        @(negedge clk);
        chk("ld_d_req", {31'h0, d_req}, 32'h1);
        chk("ld_d_addr", d_addr, 32'h0000_1000);
        chk("ld_d_wr", {31'h0, d_wr}, 32'h0);
        chk("ld_stall_addr", {31'h0, stall_req}, 32'h1);
        tick();
        d_addr_ok = 1'b0; d_data_ok = 1'b1; d_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        chk("ld_req_drop", {31'h0, d_req}, 32'h0);
        chk("ld_stall_data", {31'h0, stall_req}, 32'h1);
        tick();
        d_data_ok = 1'b0; d_rdata = 32'h0; mem_adv = 1'b1;
        @(negedge clk);
        chk("ld_m_rdata", m_rdata, 32'hDEAD_BEEF);
        chk("ld_stall_done", {31'h0, stall_req}, 32'h0);
        cnt_is("ld_cnt", 3);
        tick();
        mem_adv = 1'b0; mem_m_en = 1'b0;
        @(negedge clk);
        chk("ld_rdata_hold", m_rdata, 32'hDEAD_BEEF);
        chk("ld_idle_stall", {31'h0, stall_req}, 32'h0);
        tick();

        // 2: store with 2 addr wait cycles and 3 data wait cycles
        mem_m_en = 1'b1; mem_m_wen = 4'b0011; mem_m_vaddr = 32'hA000_0010;
        mem_m_wdata = 32'h1234_5678;
        tick();
        for (int i = 0; i < 3; i++) begin
            d_addr_ok = (i == 2);
            @(negedge clk);
            chk("st_d_req_held", {31'h0, d_req}, 32'h1);
            tick();
        end
        d_addr_ok = 1'b0;
        chk("st_d_wr", {31'h0, d_wr}, 32'h1);
        chk("st_d_wen", {28'h0, d_wen}, 32'h3);
        chk("st_d_addr", d_addr, 32'h0000_0010);
        chk("st_d_wdata", d_wdata, 32'h1234_5678);
        for (int i = 0; i < 4; i++) begin
            d_data_ok = (i == 3); d_rdata = 32'h5555_5555;
            @(negedge clk);
            chk("st_req_low", {31'h0, d_req}, 32'h0);
            chk("st_stall", {31'h0, stall_req}, 32'h1);
            tick();
        end
        d_data_ok = 1'b0; mem_adv = 1'b1;
        @(negedge clk);
        chk("st_m_rdata_keep", m_rdata, 32'hDEAD_BEEF);
        chk("st_stall_done", {31'h0, stall_req}, 32'h0);
        cnt_is("st_cnt", 11);
        tick();
        mem_adv = 1'b0; mem_m_en = 1'b0;

        // 3: flush while request is still unaccepted
        mem_m_en = 1'b1; mem_m_wen = 4'b0000; mem_m_vaddr = 32'h0000_2000;
        tick();
        flush = 1'b1;
        @(negedge clk);
        chk("fa_d_addr", d_addr, 32'h0000_2000);
        chk("fa_d_req", {31'h0, d_req}, 32'h1);
        tick();
        flush = 1'b0; mem_m_en = 1'b0;
        @(negedge clk);
        chk("fa_req_drop", {31'h0, d_req}, 32'h0);
        chk("fa_stall", {31'h0, stall_req}, 32'h0);
        cnt_is("fa_cnt", 13);
        tick();

        // 4: flush in DATA, late data discarded, next load waits
        mem_m_en = 1'b1; mem_m_vaddr = 32'h9000_0040;
        tick();
        chk("fd_d_addr", d_addr, 32'h1000_0040);
        d_addr_ok = 1'b1;
        tick();
        d_addr_ok = 1'b0; flush = 1'b1; mem_m_vaddr = 32'h0000_3000;
        @(negedge clk); chk("fd_stall_data", {31'h0, stall_req}, 32'h1);
        tick();
        flush = 1'b0;
        for (int i = 0; i < 2; i++) begin
            d_data_ok = (i == 1); d_rdata = 32'hCAFE_0000;
            @(negedge clk);
            chk("fd_stall_cancel", {31'h0, stall_req}, 32'h1);
            chk("fd_no_issue", {31'h0, d_req}, 32'h0);
            tick();
        end
        d_data_ok = 1'b0; d_rdata = 32'h0;
        @(negedge clk);
        chk("fd_m_rdata", m_rdata, 32'hDEAD_BEEF);
        chk("fd_idle_req", {31'h0, d_req}, 32'h0);
        tick();
        chk("fd_new_req", {31'h0, d_req}, 32'h1);
        chk("fd_new_addr", d_addr, 32'h0000_3000);
        cnt_is("fd_cnt_sat", 15);
        d_addr_ok = 1'b1;
        tick();
        d_addr_ok = 1'b0; d_data_ok = 1'b1; d_rdata = 32'h0BAD_F00D;
        tick();
        d_data_ok = 1'b0; d_rdata = 32'h0;

        // 5: downstream stall holds DONE without reissue
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("ds_stall", {31'h0, stall_req}, 32'h0);
            chk("ds_no_req", {31'h0, d_req}, 32'h0);
            chk("ds_m_rdata", m_rdata, 32'h0BAD_F00D);
            tick();
        end
        mem_adv = 1'b1;
        tick();
        mem_adv = 1'b0; mem_m_en = 1'b0;
        cnt_is("ds_cnt_sat", 15);

        // 6: reset in the middle of DATA
        mem_m_en = 1'b1; mem_m_vaddr = 32'h8000_0100;
        tick();
        d_addr_ok = 1'b1;
        tick();
        d_addr_ok = 1'b0;
        chk("rd_d_addr", d_addr, 32'h0000_0100);
        rst = 1'b1;
        tick();
        rst = 1'b0; mem_m_en = 1'b0;
        @(negedge clk);
        chk("rd_d_req", {31'h0, d_req}, 32'h0);
        chk("rd_d_wr", {31'h0, d_wr}, 32'h0);
        chk("rd_d_wen", {28'h0, d_wen}, 32'h0);
        chk("rd_d_addr0", d_addr, 32'h0);
        chk("rd_d_wdata", d_wdata, 32'h0);
        chk("rd_m_rdata", m_rdata, 32'h0);
        chk("rd_stall", {31'h0, stall_req}, 32'h0);
        cnt_is("rd_cnt", 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
